// File: rtl/sipo_deserializer.sv
// sipo_deserializer: MSB-first serial-in, parallel-out receiver with a
// one-word valid/ready holding register, frame resync and overrun flagging.
//
// Optional feature macro: SIPO_PARITY_EN
//   defined   -> each frame carries WIDTH data bits plus one trailing
//                even-parity bit; parity_err reports the check result
//                for the word currently held in out_data.
//   undefined -> frame is WIDTH bits; parity_err is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   serial_in    in   serial data bit, MSB first
//   serial_valid in   serial_in is sampled only when this is 1
//   sync         in   drop any partial frame and restart bit counting
//   out_data     out  assembled word (first received bit in the MSB)
//   out_valid    out  out_data holds an unconsumed word
//   out_ready    in   consumer accepts the word when out_valid & out_ready
//   busy         out  a partial frame is in progress
//   overrun      out  one-cycle pulse: a completed frame was dropped
//   parity_err   out  parity result for the word in out_data
module sipo_deserializer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] new_word;
  logic             new_perr;
  logic             complete;
  logic             handshake;
  logic             load;

  always_comb begin
    shifted   = {shreg_q[WIDTH-2:0], serial_in};
    // sync takes priority, so a sync edge can never complete a frame
    complete  = serial_valid && !sync && (cnt_q == LAST);
    handshake = (state_q == FULL) && out_ready;
`ifdef SIPO_PARITY_EN
    // The current bit is the parity bit; the data bits are already in shreg
    new_word  = shreg_q;
    new_perr  = (^shreg_q) ^ serial_in;
`else
    new_word  = shifted;
    new_perr  = 1'b0;
`endif

    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    state_d   = state_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    load      = 1'b0;

    if (sync) begin
      // A bit arriving with sync becomes bit 0 of the new frame
      cnt_d   = serial_valid ? CNT_W'(1) : '0;
      shreg_d = serial_valid ? {{(WIDTH-1){1'b0}}, serial_in} : '0;
    end else if (serial_valid) begin
      shreg_d = shifted;
      cnt_d   = complete ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          // Accept-and-reload on the same edge keeps the port bubble-free
          if (handshake) load = 1'b1;
          else           overrun_d = 1'b1;
        end else if (handshake) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (load) data_d = new_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SIPO_PARITY_EN
  logic perr_q, perr_d;

  // Parity result travels with the word; a dropped frame's result is discarded
  always_comb begin
    perr_d = perr_q;
    if (load) perr_d = new_perr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perr_q <= 1'b0;
    else          perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = new_perr;
  assign parity_err  = 1'b0;
`endif

  assign out_data  = data_q;
  assign out_valid = (state_q == FULL);
  assign busy      = (cnt_q != '0);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;
  localparam int W = 3;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         serial_in = 1'b0;
  logic         serial_valid = 1'b0;
  logic         sync = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int n_vec = 0;
  int n_err = 0;
  int ovr_seen = 0;
  logic [W:0] sb[$];   // {parity_err, data}

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in),
    .serial_valid(serial_valid), .sync(sync), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Monitor: at the falling edge, a valid & ready pair means the word is
  // taken on the next rising edge, so it is popped and compared here.
  always @(negedge clk) begin
    logic [W:0] e;
    if (reset_n && overrun) ovr_seen++;
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %0h, required none", out_data);
      end else begin
        e = sb.pop_front();
        chk("word", {27'd0, parity_err, out_data}, {27'd0, e});
      end
    end
  end

  function automatic logic [FRAME-1:0] mk(input logic [W-1:0] w);
`ifdef SIPO_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // One clock with the given serial inputs; returns 1 time unit after the edge
  task automatic step(input logic b, input logic v, input logic s);
    serial_in = b; serial_valid = v; sync = s;
    @(posedge clk); #1;
    serial_valid = 1'b0; sync = 1'b0;
  endtask

  // Send the first n bits of a frame, MSB first
  task automatic send(input logic [FRAME-1:0] f, input int n);
    for (int i = FRAME - 1; i >= FRAME - n; i--) step(f[i], 1'b1, 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_data"},   {29'd0, out_data}, 32'd0);
    chk({tag, "_out_valid"},  {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy}, 32'd0);
    chk({tag, "_overrun"},    {31'd0, overrun}, 32'd0);
    chk({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME-1:0] f;
    int ovr_base;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame 1,0,1 with out_ready low
    f = mk(3'b101);
    sb.push_back({1'b0, 3'b101});
    for (int i = FRAME - 1; i >= 0; i--) begin
      step(f[i], 1'b1, 1'b0);
      chk("basic_busy", {31'd0, busy}, {31'd0, (i != 0)});
      chk("basic_valid", {31'd0, out_valid}, {31'd0, (i == 0)});
    end
    chk("basic_data", {29'd0, out_data}, 32'd5);
    drain();
    chk("basic_consumed", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream 101, 011 with out_ready high
    ovr_base = ovr_seen;
    out_ready = 1'b1;
    sb.push_back({1'b0, 3'b101});
    sb.push_back({1'b0, 3'b011});
    send(mk(3'b101), FRAME);
    chk("b2b_valid1", {31'd0, out_valid}, 32'd1);
    send(mk(3'b011), FRAME);
    chk("b2b_valid2", {31'd0, out_valid}, 32'd1);
    chk("b2b_data2", {29'd0, out_data}, 32'd3);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_empty", {31'd0, out_valid}, 32'd0);
    chk("b2b_no_overrun", ovr_seen - ovr_base, 32'd0);

    // Handshake and completion on the same edge: new word, no bubble
    sb.push_back({1'b0, 3'b110});
    sb.push_back({1'b0, 3'b001});
    send(mk(3'b110), FRAME);
    f = mk(3'b001);
    send(f, FRAME - 1);
    out_ready = 1'b1;
    step(f[0], 1'b1, 1'b0);
    chk("nobubble_valid", {31'd0, out_valid}, 32'd1);
    chk("nobubble_data", {29'd0, out_data}, 32'd1);
    chk("nobubble_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("nobubble_empty", {31'd0, out_valid}, 32'd0);

    // Overrun: second frame dropped while out_ready low
    ovr_base = ovr_seen;
    sb.push_back({1'b0, 3'b101});
    send(mk(3'b101), FRAME);
    send(mk(3'b011), FRAME);
    chk("ovr_pulse", {31'd0, overrun}, 32'd1);
    chk("ovr_hold_data", {29'd0, out_data}, 32'd5);
    @(posedge clk); #1;
    chk("ovr_pulse_end", {31'd0, overrun}, 32'd0);
    chk("ovr_count", ovr_seen - ovr_base, 32'd1);
    drain();

    // Resync: 1,1 then sync with bit 0, then 1,0 -> 010
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    f = mk(3'b010);
    sb.push_back({1'b0, 3'b010});
    step(f[FRAME-1], 1'b1, 1'b1);
    chk("sync_busy", {31'd0, busy}, 32'd1);
    chk("sync_no_word", {31'd0, out_valid}, 32'd0);
    for (int i = FRAME - 2; i >= 0; i--) step(f[i], 1'b1, 1'b0);
    chk("sync_valid", {31'd0, out_valid}, 32'd1);
    chk("sync_data", {29'd0, out_data}, 32'd2);
    drain();

    // Stall: idle cycles with garbage on serial_in between bits -> 110
    f = mk(3'b110);
    sb.push_back({1'b0, 3'b110});
    for (int i = FRAME - 1; i >= 0; i--) begin
      step(f[i], 1'b1, 1'b0);
      if (i != 0) begin
        step(~f[i], 1'b0, 1'b0);
        step(~f[i], 1'b0, 1'b0);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        chk("stall_valid", {31'd0, out_valid}, 32'd0);
      end
    end
    chk("stall_data", {29'd0, out_data}, 32'd6);
    drain();

    // Reset mid-frame with a word held: everything lost
    send(mk(3'b011), FRAME);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    reset_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.push_back({1'b0, 3'b001});
    send(mk(3'b001), FRAME);
    chk("postrst_valid", {31'd0, out_valid}, 32'd1);
    chk("postrst_data", {29'd0, out_data}, 32'd1);
    drain();

`ifdef SIPO_PARITY_EN
    // Parity: 1,0,1,0 good; 1,0,1,1 bad
    sb.push_back({1'b0, 3'b101});
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    chk("par_ok_data", {29'd0, out_data}, 32'd5);
    chk("par_ok_err", {31'd0, parity_err}, 32'd0);
    drain();
    sb.push_back({1'b1, 3'b101});
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    chk("par_bad_err", {31'd0, parity_err}, 32'd1);
    drain();
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
